// File: rtl/rv32i_types.sv
// Shared types for the rv32i core pipeline control.
//   hazard_state_t : state encoding of the hazard controller
//     HZ_RUN         - normal issue, all hazard rules evaluated
//     HZ_LU_BUBBLE   - one load-use bubble inserted; load_use masked
//     HZ_SQUASH_WAIT - mispredict seen during an I-fetch stall; the redirect
//                      target is parked in tgt_q until the fetch returns
package rv32i_types;

  typedef enum logic [1:0] {
    HZ_RUN         = 2'd0,
    HZ_LU_BUBBLE   = 2'd1,
    HZ_SQUASH_WAIT = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_perf_ctr.sv
// Saturating event counter used by the hazard controller's performance
// monitors. Only built when HAZARD_PERF_EN is defined; otherwise this file
// is empty.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high clear
//   inc   - count one event this cycle
//   count - current value, sticks at all-ones
`ifdef HAZARD_PERF_EN
module hazard_perf_ctr #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage rv32i pipeline. Combines load-use,
// EX-stage mispredict and I/D memory handshakes into load enables and
// bubble (flush) strobes for the PC and each pipeline register, and owns
// the PC redirect. A mispredict that lands during an outstanding I-fetch
// is parked in tgt_q and replayed once the fetch returns.
//
// Optional feature macro: HAZARD_PERF_EN adds three 32-bit saturating
// performance counters (perf_lu_bubbles, perf_flushes, perf_stall_cycles).
//
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   load_use                        - load in MEM with dependent op in EX
//   br_mispredict, br_target        - EX-stage mispredict and correct PC
//   imem_read, imem_resp            - I-cache request / response
//   dmem_read, dmem_write, dmem_resp- D-cache request / response
//   pc_load, pc_redirect            - PC enable and redirect mux select
//   pc_redirect_addr                - redirect target
//   *_load                          - pipeline register load enables
//   *_flush                         - load a bubble instead of upstream data
//   perf_*                          - event counters (HAZARD_PERF_EN only)
module hazard_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_use,
  input  logic            br_mispredict,
  input  logic [XLEN-1:0] br_target,
  input  logic            imem_read,
  input  logic            imem_resp,
  input  logic            dmem_read,
  input  logic            dmem_write,
  input  logic            dmem_resp,
  output logic            pc_load,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_redirect_addr,
  output logic            if_id_load,
  output logic            id_ex_load,
  output logic            ex_mem_load,
  output logic            mem_wb_load,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            ex_mem_flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]     perf_lu_bubbles,
  output logic [31:0]     perf_flushes,
  output logic [31:0]     perf_stall_cycles
`endif
);

  hazard_state_t   state_q, state_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            resp_seen_q, resp_seen_d;
  logic            istall, dstall;

  assign istall = imem_read & ~imem_resp;
  assign dstall = (dmem_read | dmem_write) & ~dmem_resp;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HZ_RUN;
      tgt_q       <= '0;
      resp_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      resp_seen_q <= resp_seen_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no
    // path through the case leaves one unassigned (which would infer a latch).
    state_d          = state_q;
    tgt_d            = tgt_q;
    resp_seen_d      = resp_seen_q;
    pc_load          = 1'b1;
    pc_redirect      = 1'b0;
    if_id_load       = 1'b1;
    id_ex_load       = 1'b1;
    ex_mem_load      = 1'b1;
    mem_wb_load      = 1'b1;
    if_id_flush      = 1'b0;
    id_ex_flush      = 1'b0;
    ex_mem_flush     = 1'b0;
    pc_redirect_addr = (state_q == HZ_SQUASH_WAIT) ? tgt_q : br_target;

    unique case (state_q)
      HZ_RUN, HZ_LU_BUBBLE: begin
        // Leaving LU_BUBBLE is the default; only a D-stall holds it there.
        state_d = HZ_RUN;
        if (dstall) begin
          // Freeze the whole pipe; EX re-evaluates next cycle.
          {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = '0;
          state_d = state_q;
        end else if (load_use && (state_q == HZ_RUN)) begin
          pc_load      = 1'b0;
          if_id_load   = 1'b0;
          id_ex_load   = 1'b0;
          ex_mem_flush = 1'b1;
          state_d      = HZ_LU_BUBBLE;
        end else if (br_mispredict && !istall) begin
          pc_redirect = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (br_mispredict) begin
          // Fetch in flight: the PC cannot move until it returns, so the
          // target is parked and replayed from HZ_SQUASH_WAIT. istall
          // implies no response this cycle.
          tgt_d       = br_target;
          resp_seen_d = 1'b0;
          pc_load     = 1'b0;
          if_id_load  = 1'b0;
          id_ex_flush = 1'b1;
          state_d     = HZ_SQUASH_WAIT;
        end else if (istall) begin
          pc_load     = 1'b0;
          if_id_load  = 1'b0;
          id_ex_flush = 1'b1;
        end
      end

      HZ_SQUASH_WAIT: begin
        // EX holds a bubble here, so mispredict and load_use are moot.
        pc_load     = 1'b0;
        if_id_load  = 1'b0;
        id_ex_flush = 1'b1;
        if (imem_resp) resp_seen_d = 1'b1;
        if (dstall) begin
          // The response may arrive under a D-stall; it is remembered above.
          {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = '0;
          id_ex_flush = 1'b0;
        end else if (imem_resp || resp_seen_q) begin
          // The returned fetch is wrong-path: discard it and redirect.
          pc_load     = 1'b1;
          pc_redirect = 1'b1;
          if_id_load  = 1'b1;
          if_id_flush = 1'b1;
          resp_seen_d = 1'b0;
          state_d     = HZ_RUN;
        end
      end

      default: state_d = HZ_RUN;
    endcase

    // Reset holds the whole pipe and suppresses any redirect.
    if (rst) begin
      {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = '0;
      {if_id_flush, id_ex_flush, ex_mem_flush}                    = '0;
      pc_redirect = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  // A load-use bubble is exactly a RUN -> LU_BUBBLE transition outside reset.
  hazard_perf_ctr #(.W(32)) u_lu_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (!rst && (state_q == HZ_RUN) && (state_d == HZ_LU_BUBBLE)),
    .count (perf_lu_bubbles)
  );

  hazard_perf_ctr #(.W(32)) u_flush_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_redirect),
    .count (perf_flushes)
  );

  hazard_perf_ctr #(.W(32)) u_stall_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (!pc_load && !rst),
    .count (perf_stall_cycles)
  );
`endif

endmodule
